// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline stall/flush controller: FSM states,
// per-cycle action selection and the IF/ID hold/IF_flush pin patterns.
package pipe_ctrl_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    typedef enum logic [2:0] {
        ACT_RESET,
        ACT_FREEZE,
        ACT_LOADUSE,
        ACT_REDIRECT,
        ACT_FETCHWAIT,
        ACT_RUN
    } act_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // IF/ID pin pair packed as {hold, if_flush}
    localparam logic [1:0] IFID_LOAD = 2'b00;
    localparam logic [1:0] IFID_KEEP = 2'b10;
    localparam logic [1:0] IFID_NOP  = 2'b11;

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage MIPS pipeline: one prioritised
// action per cycle, data-memory wait FSM, sticky timeout flag and hazard counters.
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       if_id_rs,
    input  logic [4:0]       if_id_rt,
    input  logic             if_id_uses_rt,
    input  logic             id_ex_memread,
    input  logic [4:0]       id_ex_rt,
    input  logic             branch_taken,
    input  logic             jump,
    input  logic             imem_ready,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_write,
    output logic             if_id_hold,
    output logic             if_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_hold,
    output logic             mem_wb_bubble,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] memwait_cnt
);

    localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(MEM_TIMEOUT);

    state_t           state, state_nxt;
    act_t             act;
    logic             lu, mw, redirect;
    logic [1:0]       ifid_pins;
    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] wait_inc;
    logic             still_waiting;

    assign lu = id_ex_memread && (id_ex_rt != REG_ZERO) &&
                ((id_ex_rt == if_id_rs) || (if_id_uses_rt && (id_ex_rt == if_id_rt)));
    assign mw       = dmem_req && !dmem_ready;
    assign redirect = branch_taken || jump;

    assign wait_inc      = wait_cnt + CNT_W'(1);
    assign still_waiting = (state == MEM_WAIT) && !dmem_ready;

    always_comb begin
        state_nxt = state;
        if ((state == RUN) && mw) begin
            state_nxt = MEM_WAIT;
        end else if ((state == MEM_WAIT) && dmem_ready) begin
            state_nxt = RUN;
        end

        act = ACT_RUN;
        if (rst) begin
            act = ACT_RESET;
        end else if ((state == MEM_WAIT) || mw) begin
            act = ACT_FREEZE;
        end else if (lu) begin
            act = ACT_LOADUSE;
        end else if (redirect) begin
            act = ACT_REDIRECT;
        end else if (!imem_ready) begin
            act = ACT_FETCHWAIT;
        end

        pc_write      = 1'b1;
        ifid_pins     = IFID_LOAD;
        id_ex_flush   = 1'b0;
        ex_mem_hold   = 1'b0;
        mem_wb_bubble = 1'b0;
        case (act)
            ACT_RESET: begin
                pc_write      = 1'b0;
                ifid_pins     = IFID_NOP;
                id_ex_flush   = 1'b1;
                mem_wb_bubble = 1'b1;
            end
            // ID/EX keeps its contents through its own hold tie-in, so no flush here
            ACT_FREEZE: begin
                pc_write      = 1'b0;
                ifid_pins     = IFID_KEEP;
                ex_mem_hold   = 1'b1;
                mem_wb_bubble = 1'b1;
            end
            ACT_LOADUSE: begin
                pc_write    = 1'b0;
                ifid_pins   = IFID_KEEP;
                id_ex_flush = 1'b1;
            end
            ACT_REDIRECT: begin
                ifid_pins = IFID_NOP;
            end
            ACT_FETCHWAIT: begin
                pc_write  = 1'b0;
                ifid_pins = IFID_NOP;
            end
            default: begin
            end
        endcase
    end

    assign {if_id_hold, if_flush} = ifid_pins;

    // wait_cnt holds the ordinal of the current MEM_WAIT cycle (1 on the first)
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RUN;
            wait_cnt <= '0;
            mem_err  <= 1'b0;
        end else begin
            state <= state_nxt;
            if ((state == RUN) && mw) begin
                wait_cnt <= CNT_W'(1);
            end else if (still_waiting && (wait_cnt != '1)) begin
                wait_cnt <= wait_inc;
            end
            if (still_waiting && (wait_cnt != '1) && (wait_inc == TIMEOUT_V)) begin
                mem_err <= 1'b1;
            end
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .clr (rst),
        .inc (act == ACT_LOADUSE),
        .cnt (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk (clk),
        .clr (rst),
        .inc (act == ACT_REDIRECT),
        .cnt (flush_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_memwait_cnt (
        .clk (clk),
        .clr (rst),
        .inc (act == ACT_FREEZE),
        .cnt (memwait_cnt)
    );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: single-cycle vector table from RUN,
// then hand sequences for memory wait, timeout and reset mid-wait.
module tb_pipeline_hazard_ctrl;

    localparam int CNT_W = 16;

    // {pc_write, if_id_hold, if_flush, id_ex_flush, ex_mem_hold, mem_wb_bubble}
    localparam logic [5:0] NORM  = 6'b100000;
    localparam logic [5:0] STALL = 6'b010100;
    localparam logic [5:0] REDIR = 6'b111000;
    localparam logic [5:0] FWAIT = 6'b011000;
    localparam logic [5:0] FRZ   = 6'b010011;
    localparam logic [5:0] RSTO  = 6'b011101;

    logic             clk;
    logic             rst;
    logic [4:0]       if_id_rs, if_id_rt, id_ex_rt;
    logic             if_id_uses_rt, id_ex_memread, branch_taken, jump;
    logic             imem_ready, dmem_req, dmem_ready;
    logic             pc_write, if_id_hold, if_flush, id_ex_flush;
    logic             ex_mem_hold, mem_wb_bubble, mem_err;
    logic [CNT_W-1:0] stall_cnt, flush_cnt, memwait_cnt;

    int total  = 0;
    int passed = 0;
    int exp_stall = 0;
    int exp_flush = 0;
    int exp_mw    = 0;

    typedef struct {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       uses_rt;
        logic       memread;
        logic [4:0] ex_rt;
        logic       br;
        logic       jmp;
        logic       irdy;
        logic       dreq;
        logic       drdy;
        logic [5:0] exp;
    } vec_t;

    vec_t vecs[13];

    pipeline_hazard_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .if_id_rs      (if_id_rs),
        .if_id_rt      (if_id_rt),
        .if_id_uses_rt (if_id_uses_rt),
        .id_ex_memread (id_ex_memread),
        .id_ex_rt      (id_ex_rt),
        .branch_taken  (branch_taken),
        .jump          (jump),
        .imem_ready    (imem_ready),
        .dmem_req      (dmem_req),
        .dmem_ready    (dmem_ready),
        .pc_write      (pc_write),
        .if_id_hold    (if_id_hold),
        .if_flush      (if_flush),
        .id_ex_flush   (id_ex_flush),
        .ex_mem_hold   (ex_mem_hold),
        .mem_wb_bubble (mem_wb_bubble),
        .mem_err       (mem_err),
        .stall_cnt     (stall_cnt),
        .flush_cnt     (flush_cnt),
        .memwait_cnt   (memwait_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [4:0] rs, input logic [4:0] rt, input logic uses_rt,
                                input logic memread, input logic [4:0] ex_rt, input logic br,
                                input logic jmp, input logic irdy, input logic dreq,
                                input logic drdy, input logic [5:0] exp);
        vec_t v;
        v.rs = rs; v.rt = rt; v.uses_rt = uses_rt; v.memread = memread; v.ex_rt = ex_rt;
        v.br = br; v.jmp = jmp; v.irdy = irdy; v.dreq = dreq; v.drdy = drdy; v.exp = exp;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        if_id_rs = v.rs; if_id_rt = v.rt; if_id_uses_rt = v.uses_rt;
        id_ex_memread = v.memread; id_ex_rt = v.ex_rt;
        branch_taken = v.br; jump = v.jmp; imem_ready = v.irdy;
        dmem_req = v.dreq; dmem_ready = v.drdy;
    endtask

    task automatic idle();
        drive(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, NORM));
    endtask

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act == req) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, req);
    endtask

    task automatic chk_ctl(input string name, input logic [5:0] req);
        logic [5:0] got;
        got = {pc_write, if_id_hold, if_flush, id_ex_flush, ex_mem_hold, mem_wb_bubble};
        total++;
        if (got == req) passed++;
        else $display("FAIL %s: ctl got %b, expected %b", name, got, req);
    endtask

    task automatic chk_cnts(input string name);
        chk({name, " stall_cnt"}, int'(stall_cnt), exp_stall);
        chk({name, " flush_cnt"}, int'(flush_cnt), exp_flush);
        chk({name, " memwait_cnt"}, int'(memwait_cnt), exp_mw);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //           rs    rt    urt   mrd   exrt  br    jmp   irdy  dreq  drdy  expected
        vecs[0]  = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, NORM);
        vecs[1]  = mk(5'd2, 5'd4, 1'b1, 1'b1, 5'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, STALL);
        vecs[2]  = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, NORM);
        vecs[3]  = mk(5'd5, 5'd2, 1'b1, 1'b1, 5'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, STALL);
        vecs[4]  = mk(5'd5, 5'd2, 1'b0, 1'b1, 5'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, NORM);
        vecs[5]  = mk(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, NORM);
        vecs[6]  = mk(5'd7, 5'd7, 1'b1, 1'b0, 5'd7, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, NORM);
        vecs[7]  = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, REDIR);
        vecs[8]  = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, FWAIT);
        vecs[9]  = mk(5'd3, 5'd3, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, STALL);
        vecs[10] = mk(5'd3, 5'd3, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, REDIR);
        vecs[11] = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, REDIR);
        vecs[12] = mk(5'd9, 5'd1, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, STALL);

        // Reset
        rst = 1'b1;
        idle();
        tick();
        #3;
        chk_ctl("reset outputs", RSTO);
        tick();
        rst = 1'b0;
        chk_cnts("after reset");
        chk("after reset mem_err", int'(mem_err), 0);

        // Single-cycle vectors from RUN
        for (int i = 0; i < 13; i++) begin
            drive(vecs[i]);
            #3;
            chk_ctl($sformatf("vec%0d", i), vecs[i].exp);
            if (vecs[i].exp == STALL) exp_stall++;
            if (vecs[i].exp == REDIR) exp_flush++;
            tick();
            chk_cnts($sformatf("vec%0d", i));
        end

        // Data-memory wait: three not-ready cycles then ready; pending branch must wait
        for (int k = 0; k < 4; k++) begin
            idle();
            branch_taken = 1'b1;
            dmem_req = 1'b1;
            dmem_ready = (k == 3);
            #3;
            chk_ctl($sformatf("memwait cyc%0d", k), FRZ);
            exp_mw++;
            tick();
            chk_cnts($sformatf("memwait cyc%0d", k));
        end
        idle();
        branch_taken = 1'b1;
        #3;
        chk_ctl("redirect after wait", REDIR);
        exp_flush++;
        tick();
        chk_cnts("redirect after wait");
        idle();
        #3;
        chk_ctl("run after wait", NORM);
        chk("memwait mem_err", int'(mem_err), 0);
        tick();

        // Timeout: six not-ready cycles, flag appears in the 4th MEM_WAIT cycle
        for (int k = 0; k < 6; k++) begin
            idle();
            dmem_req = 1'b1;
            dmem_ready = 1'b0;
            #3;
            chk_ctl($sformatf("timeout cyc%0d", k), FRZ);
            chk($sformatf("timeout cyc%0d mem_err", k), int'(mem_err), (k >= 4) ? 1 : 0);
            tick();
        end

        // Reset while still waiting
        rst = 1'b1;
        #3;
        chk_ctl("reset mid-wait outputs", RSTO);
        tick();
        rst = 1'b0;
        idle();
        exp_stall = 0;
        exp_flush = 0;
        exp_mw = 0;
        #3;
        chk_ctl("run after reset", NORM);
        chk("reset mid-wait mem_err", int'(mem_err), 0);
        chk_cnts("reset mid-wait");
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
